// File: rtl/cpu_clock_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : cpu_clock_ctrl
// Brief   : CPU clock-enable generator with run / stop / single-step control.
//           Macro CPU_CLOCK_CTRL_CYCLE_COUNT_EN enables the cycle_count counter.
// Revision: 1.0
// ============================================================================
module cpu_clock_ctrl #(
    parameter int DIV_0 = 50_000_000,
    parameter int DIV_1 = 5_000_000,
    parameter int DIV_2 = 500_000,
    parameter int DIV_3 = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        run_pulse,
    input  logic        stop_pulse,
    input  logic        step_pulse,
    input  logic [1:0]  speed_sel,
    input  logic        cpu_hlt,
    output logic        cpu_ce,
    output logic        running,
    output logic        stepping,
    output logic        hlt_latched,
    output logic        tick,
    output logic [15:0] cycle_count
);

    localparam logic [25:0] C_TC_0 = 26'(DIV_0 - 1);
    localparam logic [25:0] C_TC_1 = 26'(DIV_1 - 1);
    localparam logic [25:0] C_TC_2 = 26'(DIV_2 - 1);
    localparam logic [25:0] C_TC_3 = 26'(DIV_3 - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_STEP = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [25:0] cnt_q, cnt_d;
    logic [1:0]  sel_q;
    logic        ce_q, ce_d;
    logic        running_q, stepping_q;
    logic        hlt_q, hlt_d;
    logic        tick_q;

    logic [25:0] w_tc_val;
    logic        w_sel_chg;
    logic        w_tc;

    always_comb begin
        w_tc_val = C_TC_0;
        case (speed_sel)
            2'd0:    w_tc_val = C_TC_0;
            2'd1:    w_tc_val = C_TC_1;
            2'd2:    w_tc_val = C_TC_2;
            default: w_tc_val = C_TC_3;
        endcase
    end

    // A speed change restarts the count, so it never completes a period itself.
    assign w_sel_chg = (speed_sel != sel_q);
    assign w_tc      = (cnt_q == w_tc_val) && !w_sel_chg;

    always_comb begin
        state_d = state_q;
        ce_d    = 1'b0;
        hlt_d   = hlt_q;
        cnt_d   = cnt_q + 26'd1;
        case (state_q)
            ST_IDLE: begin
                if (!hlt_q) begin
                    if (run_pulse)
                        state_d = ST_RUN;
                    else if (step_pulse)
                        state_d = ST_STEP;
                end
            end
            ST_RUN: begin
                if (cpu_hlt) begin
                    state_d = ST_IDLE;
                    hlt_d   = 1'b1;
                end else if (stop_pulse) begin
                    state_d = ST_IDLE;
                end else if (w_tc) begin
                    ce_d = 1'b1;
                end
            end
            ST_STEP: begin
                if (cpu_hlt) begin
                    state_d = ST_IDLE;
                    hlt_d   = 1'b1;
                end else if (stop_pulse) begin
                    state_d = ST_IDLE;
                end else if (w_tc) begin
                    ce_d    = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        if ((state_d != state_q) || (state_q == ST_IDLE) || w_sel_chg || w_tc)
            cnt_d = '0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            sel_q      <= speed_sel;
            ce_q       <= 1'b0;
            running_q  <= 1'b0;
            stepping_q <= 1'b0;
            hlt_q      <= 1'b0;
            tick_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            sel_q      <= speed_sel;
            ce_q       <= ce_d;
            running_q  <= (state_d == ST_RUN);
            stepping_q <= (state_d == ST_STEP);
            hlt_q      <= hlt_d;
            if (ce_d)
                tick_q <= ~tick_q;
        end
    end

`ifdef CPU_CLOCK_CTRL_CYCLE_COUNT_EN
    logic [15:0] cycle_cnt_q;

    always_ff @(posedge clk) begin
        if (reset)
            cycle_cnt_q <= 16'd0;
        else if (ce_d)
            cycle_cnt_q <= cycle_cnt_q + 16'd1;
    end

    assign cycle_count = cycle_cnt_q;
`else
    assign cycle_count = 16'd0;
`endif

    assign cpu_ce      = ce_q;
    assign running     = running_q;
    assign stepping    = stepping_q;
    assign hlt_latched = hlt_q;
    assign tick        = tick_q;

endmodule
`default_nettype wire

// File: tb/tb_cpu_clock_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : tb_cpu_clock_ctrl
// Brief   : Directed and randomized bench for cpu_clock_ctrl (DIVs 4/2/3/1).
// Revision: 1.0
// ============================================================================
module tb_cpu_clock_ctrl;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        run_pulse = 1'b0;
    logic        stop_pulse = 1'b0;
    logic        step_pulse = 1'b0;
    logic [1:0]  speed_sel = 2'd0;
    logic        cpu_hlt = 1'b0;
    logic        cpu_ce;
    logic        running;
    logic        stepping;
    logic        hlt_latched;
    logic        tick;
    logic [15:0] cycle_count;

    int checks = 0;
    int failures = 0;

    cpu_clock_ctrl #(
        .DIV_0(4),
        .DIV_1(2),
        .DIV_2(3),
        .DIV_3(1)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .run_pulse  (run_pulse),
        .stop_pulse (stop_pulse),
        .step_pulse (step_pulse),
        .speed_sel  (speed_sel),
        .cpu_hlt    (cpu_hlt),
        .cpu_ce     (cpu_ce),
        .running    (running),
        .stepping   (stepping),
        .hlt_latched(hlt_latched),
        .tick       (tick),
        .cycle_count(cycle_count)
    );

    always #5 clk = ~clk;

    // Reference model: mode 0=idle 1=run 2=step; elapsed = cycles already spent
    // in the current divide window.
    int       m_mode;
    int       m_elapsed;
    int       m_prev_sel;
    bit       m_latched;
    bit       m_tick;
    int       m_count;
    bit       m_ce;

    function automatic int div_of(input int sel);
        case (sel)
            0:       return 4;
            1:       return 2;
            2:       return 3;
            default: return 1;
        endcase
    endfunction

    task automatic model_reset(input int sel);
        m_mode = 0; m_elapsed = 0; m_prev_sel = sel;
        m_latched = 0; m_tick = 0; m_count = 0; m_ce = 0;
    endtask

    task automatic model_step(input bit r, input bit s, input bit st, input int sel, input bit h);
        bit chg, due;
        int nmode;
        chg   = (sel != m_prev_sel);
        due   = (m_mode != 0) && !chg && (m_elapsed + 1 == div_of(sel));
        nmode = m_mode;
        m_ce  = 0;
        if (m_mode == 0) begin
            if (!m_latched && r)       nmode = 1;
            else if (!m_latched && st) nmode = 2;
        end else if (h) begin
            nmode = 0; m_latched = 1;
        end else if (s) begin
            nmode = 0;
        end else if (due) begin
            m_ce = 1;
            if (m_mode == 2) nmode = 0;
        end
        if (nmode != m_mode || chg || due || m_mode == 0) m_elapsed = 0;
        else m_elapsed++;
        m_prev_sel = sel;
        m_mode = nmode;
        if (m_ce) begin
            m_tick = ~m_tick;
`ifdef CPU_CLOCK_CTRL_CYCLE_COUNT_EN
            m_count = (m_count + 1) % 65536;
`endif
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_model();
        chk("m_cpu_ce", 32'(cpu_ce), 32'(m_ce));
        chk("m_running", 32'(running), 32'(m_mode == 1));
        chk("m_stepping", 32'(stepping), 32'(m_mode == 2));
        chk("m_hlt_latched", 32'(hlt_latched), 32'(m_latched));
        chk("m_tick", 32'(tick), 32'(m_tick));
        chk("m_cycle_count", 32'(cycle_count), 32'(m_count));
    endtask

    // Drive one cycle of inputs, advance past the edge, update model and compare.
    task automatic cyc(input bit r, input bit s, input bit st, input logic [1:0] sel,
                       input bit h, input bit rst);
        run_pulse = r; stop_pulse = s; step_pulse = st;
        speed_sel = sel; cpu_hlt = h; reset = rst;
        @(posedge clk);
        #1;
        if (rst) model_reset(int'(sel));
        else     model_step(r, s, st, int'(sel), h);
        check_model();
    endtask

    task automatic idle(input int n, input logic [1:0] sel);
        for (int i = 0; i < n; i++) cyc(0, 0, 0, sel, 0, 0);
    endtask

    int ce_seen;

`ifdef CPU_CLOCK_CTRL_CYCLE_COUNT_EN
    localparam int EXP_CNT3 = 3;
`else
    localparam int EXP_CNT3 = 0;
`endif

    initial begin
        // Reset state
        cyc(0, 0, 0, 2'd0, 0, 1);
        cyc(0, 0, 0, 2'd0, 0, 1);
        chk("rst_ce", 32'(cpu_ce), 0);
        chk("rst_running", 32'(running), 0);
        chk("rst_count", 32'(cycle_count), 0);

        // Free run at DIV=4: first cpu_ce 5 cycles after run_pulse, then every 4
        idle(8, 2'd0);
        cyc(1, 0, 0, 2'd0, 0, 0);
        chk("run_running", 32'(running), 1);
        idle(3, 2'd0);
        chk("run_no_ce_early", 32'(cpu_ce), 0);
        idle(1, 2'd0);
        chk("run_ce1", 32'(cpu_ce), 1);
        idle(4, 2'd0);
        chk("run_ce2", 32'(cpu_ce), 1);
        idle(4, 2'd0);
        chk("run_ce3", 32'(cpu_ce), 1);
        chk("run_count3", 32'(cycle_count), 32'(EXP_CNT3));
        chk("run_tick", 32'(tick), 1);
        cyc(0, 1, 0, 2'd0, 0, 0);
        chk("stop_running", 32'(running), 0);

        // Speed change the cycle after a cpu_ce restarts the count at DIV=2
        cyc(1, 0, 0, 2'd0, 0, 0);
        idle(4, 2'd0);
        chk("spd_ce_before", 32'(cpu_ce), 1);
        idle(1, 2'd0);
        cyc(0, 0, 0, 2'd1, 0, 0);
        chk("spd_ce_c1", 32'(cpu_ce), 0);
        idle(1, 2'd1);
        chk("spd_ce_c2", 32'(cpu_ce), 0);
        idle(1, 2'd1);
        chk("spd_ce_c3", 32'(cpu_ce), 1);
        idle(2, 2'd1);
        chk("spd_ce_c5", 32'(cpu_ce), 1);
        cyc(0, 1, 0, 2'd1, 0, 0);

        // Single step at DIV=3
        idle(2, 2'd2);
        cyc(0, 0, 1, 2'd2, 0, 0);
        chk("step_stepping1", 32'(stepping), 1);
        idle(2, 2'd2);
        chk("step_stepping3", 32'(stepping), 1);
        chk("step_no_ce", 32'(cpu_ce), 0);
        idle(1, 2'd2);
        chk("step_ce", 32'(cpu_ce), 1);
        chk("step_back_idle", 32'(stepping), 0);
        ce_seen = 0;
        for (int i = 0; i < 20; i++) begin
            idle(1, 2'd2);
            ce_seen += int'(cpu_ce);
        end
        chk("step_quiet", 32'(ce_seen), 0);

        // Stop coincident with terminal count suppresses that cpu_ce
        cyc(1, 0, 0, 2'd0, 0, 0);
        idle(3, 2'd0);
        cyc(0, 1, 0, 2'd0, 0, 0);
        chk("stop_tc_ce", 32'(cpu_ce), 0);
        chk("stop_tc_running", 32'(running), 0);

        // run_pulse and step_pulse together go to RUN
        cyc(1, 0, 1, 2'd0, 0, 0);
        chk("both_running", 32'(running), 1);
        chk("both_stepping", 32'(stepping), 0);
        cyc(0, 1, 0, 2'd0, 0, 0);

        // Reset in the terminal-count cycle suppresses the due cpu_ce
        cyc(1, 0, 0, 2'd0, 0, 0);
        idle(3, 2'd0);
        cyc(0, 0, 0, 2'd0, 0, 1);
        chk("rst_mid_ce", 32'(cpu_ce), 0);
        chk("rst_mid_running", 32'(running), 0);
        chk("rst_mid_tick", 32'(tick), 0);
        chk("rst_mid_count", 32'(cycle_count), 0);

        // Halt at DIV=1 latches and locks out run/step until reset
        idle(2, 2'd3);
        cyc(1, 0, 0, 2'd3, 0, 0);
        idle(1, 2'd3);
        chk("hlt_pre_ce", 32'(cpu_ce), 1);
        idle(4, 2'd3);
        cyc(0, 0, 0, 2'd3, 1, 0);
        chk("hlt_ce", 32'(cpu_ce), 0);
        chk("hlt_latched", 32'(hlt_latched), 1);
        chk("hlt_running", 32'(running), 0);
        cyc(1, 0, 0, 2'd3, 0, 0);
        cyc(0, 0, 1, 2'd3, 0, 0);
        ce_seen = 0;
        for (int i = 0; i < 5; i++) begin
            idle(1, 2'd3);
            ce_seen += int'(cpu_ce) + int'(running) + int'(stepping);
        end
        chk("hlt_lockout", 32'(ce_seen), 0);
        cyc(0, 0, 0, 2'd3, 0, 1);
        chk("hlt_cleared", 32'(hlt_latched), 0);

        // Randomized traffic checked against the model every cycle
        for (int i = 0; i < 1500; i++) begin
            logic [1:0] sel;
            sel = ($urandom_range(0, 24) == 0) ? 2'($urandom_range(0, 3)) : speed_sel;
            cyc($urandom_range(0, 14) == 0, $urandom_range(0, 29) == 0,
                $urandom_range(0, 14) == 0, sel,
                $urandom_range(0, 99) == 0, $urandom_range(0, 119) == 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
